imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory read port. Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Issues one write per word into the instruction memory's load port at byte addresses BASE_ADDR, BASE_ADDR+4, and so on.
- Holds the CPU in reset via cpu_hold while loading is in progress.
- Sits between the boot/UART byte source and instruction_memory.

Parameters:
- BASE_ADDR, 32'd0, byte address of the first written word.
- MAX_WORDS, 64, instruction memory depth in words; larger requests are rejected.
- COUNT_W, 8, width of num_words and of the internal word index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- num_words  input  COUNT_W  number of words to load; latched when start is accepted.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the write, always a multiple of 4.
- wr_data  output  32  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  level; set on completion, cleared by the next accepted start.
- error  output  1  level; valid while done=1.
- cpu_hold  output  1  high in RECV and WRITE; CPU must stay in reset.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=0.
  - Byte counter and word index are cleared.
- Reset mid-load aborts the load. Words already written stay in memory. No further writes occur.
- States: IDLE, RECV, WRITE, DONE (CHECK is added with the optional feature).
- IDLE/DONE, on start=1:
  - Latch num_words.
  - Clear done and error, word index and byte counter.
  - If num_words==0: go to DONE with error=0 and no writes.
  - If num_words>MAX_WORDS: go to DONE with error=1 and no writes.
  - Otherwise go to RECV.
  - The accepting transition takes effect on the next clock edge.
- RECV:
  - byte_ready=1, busy=1, cpu_hold=1.
  - A byte transfers only when byte_valid && byte_ready.
  - Byte k (k=0..3) is placed in word bits [8k+7:8k] (little-endian).
  - When the 4th byte is accepted, go to WRITE. byte_ready stays 1 throughout RECV; there are no bubbles inside a word.
- WRITE (exactly one cycle):
  - wr_en=1, wr_addr=BASE_ADDR+4*index, wr_data=assembled word.
  - byte_ready=0, so a byte offered in this cycle is held off and not lost.
  - Next, index increments. If the new index==num_words, go to DONE (or CHECK); otherwise go to RECV.
- wr_en, wr_addr and wr_data are registered. wr_en is 0 in every state other than WRITE. wr_addr and wr_data hold their last values.
- DONE:
  - done=1, busy=0, cpu_hold=0, byte_ready=0.
  - Bytes offered here are ignored and not consumed.
- start is ignored while busy=1.
- Address arithmetic is 32-bit unsigned, with wrap modulo 2^32.
- Throughput: 5 cycles per word at full stream rate (4 RECV + 1 WRITE).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR of all accepted data bytes is accumulated, cleared on start.
  - After the last WRITE, state CHECK asserts byte_ready=1 and accepts one checksum byte.
  - error=1 if that byte does not equal the accumulated XOR; then go to DONE.
  - cpu_hold stays 1 during CHECK.
- When undefined: CHECK does not exist, the last WRITE goes directly to DONE, and error comes only from the num_words>MAX_WORDS check.

Test Plan:
- Load 3 words, bytes 13 00 50 00 | 93 00 10 00 | B3 01 00 40, byte_valid continuous:
  - 3 wr_en pulses, at wr_addr 0/4/8 with wr_data 32'h00500013 / 32'h00100093 / 32'h400001B3.
  - done=1 at cycle 16 after start; cpu_hold=1 throughout the load.
- Gapped stream, byte_valid toggling 1/0 every cycle, 1 word AA BB CC DD:
  - Single write of 32'hDDCCBBAA at BASE_ADDR; no byte is duplicated or dropped.
- num_words=0 -> DONE next cycle with error=0 and no wr_en. num_words=65 with MAX_WORDS=64 -> done=1, error=1, no wr_en.
- Assert reset after 6 accepted bytes of a 2-word load:
  - All outputs go to 0 immediately; exactly 1 write has occurred.
  - A new start then reloads from BASE_ADDR.
- start pulsed while in RECV -> ignored; latched num_words is unchanged. A byte held valid during WRITE is accepted in the next RECV cycle.
- With IMEM_LOADER_CHECKSUM_EN, 1 word 01 02 04 08:
  - Checksum 0F -> done=1, error=0.
  - Checksum 0E -> done=1, error=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs little-endian bytes into 32-bit words
// and writes them from BASE_ADDR upward. Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 64,
  parameter int          COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_words,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [31:0]        wr_addr,
  output logic [31:0]        wr_data,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               cpu_hold
);

  localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q;
  logic [COUNT_W-1:0] index_q;
  logic [COUNT_W-1:0] index_nxt;
  logic [COUNT_W-1:0] num_words_q;
  logic [23:0]        word_q;
  logic               error_q;
  logic               start_fire;
  logic               byte_fire;
  logic               last_byte;
  logic               too_many;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  assign byte_fire = byte_valid && byte_ready;
  assign last_byte = (byte_cnt_q == 2'd3);
  assign index_nxt = index_q + COUNT_W'(1);
  assign too_many  = (32'(num_words) > MAX_W32);
  assign error     = error_q;

  // NOTE: every output and next-state value gets a default before the case
  // statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    start_fire = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          start_fire = 1'b1;
          if (num_words == '0 || too_many) state_d = S_DONE;
          else                              state_d = S_RECV;
        end
      end
      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (index_nxt == num_words_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      index_q     <= '0;
      num_words_q <= '0;
      word_q      <= '0;
      error_q     <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      wr_en <= 1'b0;

      if (start_fire) begin
        num_words_q <= num_words;
        index_q     <= '0;
        byte_cnt_q  <= '0;
        error_q     <= too_many;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q      <= '0;
`endif
      end

      // Bytes shift in from the top so byte 0 lands in bits [7:0] once the word is complete.
      if (state_q == S_RECV && byte_fire) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        word_q     <= {byte_in, word_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= csum_q ^ byte_in;
`endif
        if (last_byte) begin
          wr_en   <= 1'b1;
          wr_data <= {byte_in, word_q};
          wr_addr <= BASE_ADDR + (32'(index_q) << 2);
        end
      end

      if (state_q == S_WRITE) index_q <= index_nxt;

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state_q == S_CHECK && byte_valid) error_q <= (byte_in != csum_q);
`endif
    end
  end

endmodule
